servo_axil_slave: RTL and testbench
===================================

SERVO_AXIL_SLAVE -- requirements
Module: servo_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; 4 registers decoded on ADDR[3:2].
REQ-003 SHALL provide ports:
- ACLK, input, 1: single clock; all logic on rising edge.
- ARESET, input, 1: reset, asynchronous, active-high.
- AWADDR/AWPROT/AWVALID, input, 4/3/1: write address channel.
- AWREADY, output, 1: write address channel ready.
- WDATA/WSTRB/WVALID, input, 32/4/1: write data channel.
- WREADY, output, 1: write data channel ready.
- BRESP/BVALID, output, 2/1: write response.
- BREADY, input, 1: write response ready.
- ARADDR/ARPROT/ARVALID, input, 4/3/1: read address channel.
- ARREADY, output, 1: read address channel ready.
- RDATA/RRESP/RVALID, output, 32/2/1: read data channel.
- RREADY, input, 1: read data ready.
- pwm_out, output, 1: servo pulse.

Function
REQ-004 SHALL implement registers: REG0 CTRL (bit0 = enable), REG1 PERIOD (cycles), REG2 PULSE (high cycles), REG3 SCRATCH; all 32 bits, read back exactly as written.
REQ-005 SHALL buffer AW and W independently (one entry each); AWREADY = AW buffer empty; WREADY = W buffer empty; AW and W may arrive in any order or the same cycle.
REQ-006 SHALL commit a write in the cycle both buffers are full and no unaccepted B is pending; per-byte update by WSTRB; both buffers free on commit.
REQ-007 SHALL assert BVALID on the edge after commit, BRESP = 2'b00, held until BREADY; back-to-back commit allowed in the BVALID&&BREADY cycle.
REQ-008 SHALL assert ARREADY while no RVALID is pending; on ARVALID&&ARREADY, register RDATA of the addressed register, RVALID next edge, RRESP = 2'b00, held stable until RREADY.
REQ-009 SHALL return the pre-commit value when a read is accepted in the same cycle as a write commit to the same register.
REQ-010 SHALL ignore AWPROT/ARPROT and ADDR[1:0].
REQ-011 SHALL, while CTRL[0]=1, run counter 0..PERIOD_active-1, wrapping to 0; pwm_out = (counter < PULSE_active), registered (1-cycle latency).
REQ-012 SHALL load PERIOD_active/PULSE_active from REG1/REG2 only at counter wrap or enable rising edge; mid-period writes take effect next period.
REQ-013 SHALL hold counter 0 and pwm_out 0 when PERIOD_active = 0 or CTRL[0]=0; disabling mid-period forces pwm_out 0 next edge.
REQ-014 SHALL drive pwm_out constantly 1 while enabled when PULSE_active >= PERIOD_active > 0.

Reset
REQ-015 SHALL on ARESET asynchronously clear all registers, buffers, counter; AWREADY=WREADY=ARREADY=1 after release; BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0, pwm_out=0.
REQ-016 SHALL discard any buffered or in-flight transaction when reset asserts mid-operation; no response is issued for it.

Configuration
REQ-017 SHALL use macro SERVO_PWM_EN: defined -> PWM generator instantiated per REQ-011..014; undefined -> generator absent, pwm_out tied 0, registers still fully R/W.

Structure
REQ-018 SHALL place register-index constants (REG_CTRL=0..REG_SCRATCH=3), CTRL_EN_BIT, and the OKAY response constant in package servo_axil_pkg.
REQ-019 SHALL implement the PWM counter/shadow logic in sub-module servo_pwm_gen; AXI handshake and register file stay in servo_axil_slave.

Verification
REQ-020 SHALL cover sequential writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads -> RDATA 1,2,3,4, BRESP=RRESP=0.
REQ-021 SHALL cover W two cycles before AW, then AW with BREADY held low 5 cycles -> one commit, BVALID stable 5 cycles, AWREADY/WREADY low until BREADY.
REQ-022 SHALL cover write 0xAABBCCDD to 0xC then WSTRB=4'b0010 data 0x11223344 -> read 0xAABB33DD.
REQ-023 SHALL cover PERIOD=10, PULSE=3, CTRL=1 -> pwm_out high 3, low 7 cycles repeating; PULSE=12 -> constant high from next period.
REQ-024 SHALL cover ARESET mid-write (AW buffered, W not yet) -> after release BVALID=0, REG0 = 0, AWREADY=1.
REQ-025 SHALL cover build without SERVO_PWM_EN, CTRL=1, PERIOD=10 -> pwm_out stays 0, readback 1/10 correct.

Source files
------------

// File: rtl/servo_axil_pkg.sv
// Shared constants for the servo AXI4-Lite slave: register indices, control bits, response codes.
package servo_axil_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PULSE   = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int         CTRL_EN_BIT = 0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: free-running period counter with shadow PERIOD/PULSE values
// that are only reloaded at wrap or on the enable rising edge.
module servo_pwm_gen #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] period,
    input  logic [DATA_W-1:0] pulse,
    output logic              pwm_out
);

    logic              en_d;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] period_act;
    logic [DATA_W-1:0] pulse_act;
    logic              en_rise;
    logic              wrap;

    assign en_rise = enable && !en_d;
    assign wrap    = (period_act != '0) && (cnt == period_act - DATA_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d       <= 1'b0;
            cnt        <= '0;
            period_act <= '0;
            pulse_act  <= '0;
            pwm_out    <= 1'b0;
        end else begin
            en_d <= enable;
            if (!enable) begin
                cnt     <= '0;
                pwm_out <= 1'b0;
            end else begin
                if (en_rise || wrap) begin
                    period_act <= period;
                    pulse_act  <= pulse;
                    cnt        <= '0;
                end else if (period_act != '0) begin
                    cnt <= cnt + DATA_W'(1);
                end
                // Shadows are stale in the enable-edge cycle, so the first high cycle follows it.
                pwm_out <= !en_rise && (period_act != '0) && (cnt < pulse_act);
            end
        end
    end

endmodule

// File: rtl/servo_axil_slave.sv
// AXI4-Lite slave with four 32-bit registers driving a servo PWM generator.
// Define SERVO_PWM_EN to build the generator; otherwise pwm_out is tied low.
module servo_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic                            pwm_out
);
    import servo_axil_pkg::*;

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]     old_v,
                                                  input logic [DW-1:0]     new_v,
                                                  input logic [STRB_W-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    logic              aw_full;
    logic [1:0]        aw_idx;
    logic              w_full;
    logic [DW-1:0]     w_data;
    logic [STRB_W-1:0] w_strb;
    logic              bvalid_q;
    logic              rvalid_q;
    logic [DW-1:0]     rdata_q;
    logic [DW-1:0]     regs [4];
    logic              commit;
    logic              rd_accept;
    logic              unused_bits;

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign AWREADY   = !aw_full;
    assign WREADY    = !w_full;
    assign ARREADY   = !rvalid_q;
    assign BVALID    = bvalid_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign BRESP     = RESP_OKAY;
    assign RRESP     = RESP_OKAY;

    // A new commit may overlap the cycle in which the previous response is taken.
    assign commit    = aw_full && w_full && (!bvalid_q || BREADY);
    assign rd_accept = ARVALID && !rvalid_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
        end else begin
            if (AWVALID && !aw_full) begin
                aw_full <= 1'b1;
                aw_idx  <= AWADDR[3:2];
            end
            if (WVALID && !w_full) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Reads sample regs before this cycle's commit lands, giving pre-commit data on collision.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (rd_accept) begin
                rvalid_q <= 1'b1;
                rdata_q  <= regs[ARADDR[3:2]];
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[aw_idx] <= merge_bytes(regs[aw_idx], w_data, w_strb);
        end
    end

`ifdef SERVO_PWM_EN
    servo_pwm_gen #(
        .DATA_W (DW)
    ) u_pwm (
        .clk     (ACLK),
        .rst     (ARESET),
        .enable  (regs[REG_CTRL][CTRL_EN_BIT]),
        .period  (regs[REG_PERIOD]),
        .pulse   (regs[REG_PULSE]),
        .pwm_out (pwm_out)
    );
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_servo_axil_slave.sv
// Scoreboard bench for servo_axil_slave; PWM checks follow whether SERVO_PWM_EN is defined.
module tb_servo_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        pwm_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  exp_b [$];
    logic [31:0] exp_r [$];

    servo_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .pwm_out (pwm_out)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Monitor: handshakes seen at the negedge complete on the following rising edge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) check("b_unexpected", 32'(BVALID), 32'd0);
                else check("bresp", 32'(BRESP), 32'(exp_b.pop_front()));
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) check("r_unexpected", 32'(RVALID), 32'd0);
                else begin
                    check("rresp", 32'(RRESP), 32'd0);
                    check("rdata", RDATA, exp_r.pop_front());
                end
            end
        end
    end

    task automatic wait_b();
        int n = 0;
        while (exp_b.size() != 0 && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        if (exp_b.size() != 0) begin
            check("b_timeout", 32'(exp_b.size()), 32'd0);
            exp_b.delete();
        end
        @(posedge ACLK); #1;
    endtask

    task automatic wait_r();
        int n = 0;
        while (exp_r.size() != 0 && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        if (exp_r.size() != 0) begin
            check("r_timeout", 32'(exp_r.size()), 32'd0);
            exp_r.delete();
        end
        @(posedge ACLK); #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int  n = 0;
        bit  aw_hs, w_hs;
        AWADDR = a; AWVALID = 1'b1;
        WDATA  = d; WSTRB   = s; WVALID = 1'b1;
        exp_b.push_back(2'b00);
        while (AWVALID || WVALID) begin
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs)  WVALID  = 1'b0;
            if (++n > 50) begin
                check("write_accept_timeout", {AWVALID, WVALID}, 32'd0);
                AWVALID = 1'b0; WVALID = 1'b0;
            end
        end
        wait_b();
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        int n = 0;
        bit hs;
        ARADDR = a; ARVALID = 1'b1;
        exp_r.push_back(exp);
        while (ARVALID) begin
            @(negedge ACLK);
            hs = ARREADY;
            @(posedge ACLK); #1;
            if (hs) ARVALID = 1'b0;
            if (++n > 50) begin
                check("read_accept_timeout", 32'(ARVALID), 32'd0);
                ARVALID = 1'b0;
            end
        end
        wait_r();
    endtask

    initial begin
        bit   found;
        logic prev;
        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA  = '0; WSTRB  = '0; WVALID  = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        // Reset state
        @(negedge ACLK);
        check("rst_ready", {AWREADY, WREADY, ARREADY}, 32'h7);
        check("rst_valid", {BVALID, RVALID}, 32'h0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_resp",  {BRESP, RRESP}, 32'h0);
        check("rst_pwm",   32'(pwm_out), 32'd0);
        @(posedge ACLK); #1;
        axi_read(4'h4, 32'h0);

        // Sequential writes and readback; odd low address bits and PROT are ignored
        axi_write(4'h0, 32'd1, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        AWPROT = 3'b111;
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'hC, 32'd4, 4'hF);
        AWPROT = 3'b000;
        axi_read(4'h0, 32'd1);
        axi_read(4'h4, 32'd2);
        ARPROT = 3'b101;
        axi_read(4'h8, 32'd3);
        axi_read(4'hC, 32'd4);
        ARPROT = 3'b000;
        axi_read(4'h7, 32'd2);

        // Byte strobes
        axi_write(4'hC, 32'hAABBCCDD, 4'hF);
        axi_write(4'hC, 32'h11223344, 4'b0010);
        axi_read(4'hC, 32'hAABB33DD);

        // W ahead of AW, B held off, second write queued behind the pending response
        BREADY = 1'b0;
        WDATA = 32'h0000_00A1; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1 WVALID = 1'b0;
        @(negedge ACLK);
        check("w_only_ready", {AWREADY, WREADY}, 32'h2);
        check("w_only_no_b", 32'(BVALID), 32'd0);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("w_only_no_b2", 32'(BVALID), 32'd0);
        @(posedge ACLK); #1;
        AWADDR = 4'hC; AWVALID = 1'b1;
        exp_b.push_back(2'b00);
        @(posedge ACLK); #1 AWVALID = 1'b0;
        @(posedge ACLK); #1;
        AWADDR = 4'hC; AWVALID = 1'b1; WDATA = 32'h0000_00B2; WVALID = 1'b1;
        exp_b.push_back(2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bvalid_hold", {BVALID, BRESP}, 32'h4);
            if (i > 0) check("ready_low_while_b", {AWREADY, WREADY}, 32'h0);
            @(posedge ACLK); #1;
            AWVALID = 1'b0; WVALID = 1'b0;
        end
        // Release B and read SCRATCH in the cycle the queued write commits
        BREADY = 1'b1;
        ARADDR = 4'hC; ARVALID = 1'b1;
        exp_r.push_back(32'h0000_00A1);
        @(posedge ACLK); #1 ARVALID = 1'b0;
        wait_b();
        wait_r();
        axi_read(4'hC, 32'h0000_00B2);

        // Reset while a write address is buffered
        axi_write(4'h0, 32'h0000_0005, 4'hF);
        AWADDR = 4'h0; AWVALID = 1'b1;
        @(posedge ACLK); #1 AWVALID = 1'b0;
        @(negedge ACLK);
        check("aw_buffered", 32'(AWREADY), 32'd0);
        #2 ARESET = 1'b1;
        #1 check("async_clear_awready", 32'(AWREADY), 32'd1);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        check("post_rst_bvalid", 32'(BVALID), 32'd0);
        check("post_rst_awready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        axi_read(4'h0, 32'h0);

`ifdef SERVO_PWM_EN
        axi_write(4'h4, 32'd10, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        found = 1'b0;
        prev  = pwm_out;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge ACLK);
            if (pwm_out && !prev) found = 1'b1;
            prev = pwm_out;
        end
        check("pwm_start", 32'(found), 32'd1);
        for (int i = 0; i < 30; i++) begin
            check("pwm_pattern", 32'(pwm_out), 32'((i % 10) < 3));
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        axi_write(4'h8, 32'd12, 4'hF);
        repeat (12) @(negedge ACLK);
        for (int i = 0; i < 20; i++) begin
            check("pwm_const_high", 32'(pwm_out), 32'd1);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        axi_write(4'h0, 32'd0, 4'hF);
        repeat (2) @(negedge ACLK);
        check("pwm_disabled", 32'(pwm_out), 32'd0);
        @(posedge ACLK); #1;
        axi_read(4'h4, 32'd10);
        axi_read(4'h8, 32'd12);
`else
        axi_write(4'h0, 32'd1, 4'hF);
        axi_write(4'h4, 32'd10, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            if (i % 10 == 9) check("pwm_tied_low", 32'(pwm_out), 32'd0);
        end
        @(posedge ACLK); #1;
        axi_read(4'h0, 32'd1);
        axi_read(4'h4, 32'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
